ram_access_master: RTL

- Processor-side initiator for the 16-bit RAM request port; sdram_block is the responder on the other end.
- Converts 8-bit CPU loads and stores on a 25-bit byte address into 16-bit word transactions on ram_addr, ram_wr_data, ram_rd_data, ram_wr_en, ram_rd_en, ram_busy, ram_rd_ready and ram_rd_ack.
- Byte stores are read-modify-write sequences.
- A one-word last-read buffer short-circuits repeated loads.

---
 rtl/ram_access_master.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/ram_access_master.sv
// Byte-wide CPU load/store initiator for a 16-bit word RAM port.
// Stores are read-modify-write; a one-word buffer short-circuits repeated loads.
module ram_access_master #(
   parameter int TIMEOUT   = 255,
   parameter int WR_SETTLE = 2,
   parameter bit BUF_EN    = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [24:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   output logic [7:0]  cpu_rdata,
   output logic        cpu_done,
   output logic        cpu_err,
   output logic        cpu_stall,
   output logic [23:0] ram_addr,
   output logic [15:0] ram_wr_data,
   input  logic [15:0] ram_rd_data,
   output logic        ram_wr_en,
   output logic        ram_rd_en,
   input  logic        ram_busy,
   input  logic        ram_rd_ready,
   output logic        ram_rd_ack,
   output logic [2:0]  dbg_state
);

   // Handshakes: cpu_req is taken only in IDLE and answered by exactly one cpu_done
   // pulse; ram_rd_en/ram_wr_en are single-cycle strobes issued only while ram_busy=0;
   // each ram_rd_ready beat is popped by a ram_rd_ack pulse on the following cycle.

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_ACCEPT   = 3'd1,
      S_RD_ISSUE = 3'd2,
      S_RD_WAIT  = 3'd3,
      S_MERGE    = 3'd4,
      S_WR_ISSUE = 3'd5,
      S_WR_WAIT  = 3'd6,
      S_DONE     = 3'd7
   } state_t;

   localparam int CLOG = $clog2(TIMEOUT + 1);
   localparam int CW   = (CLOG > 8) ? CLOG : 8;
   localparam logic [CW-1:0] CNT_MAX = '1;
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] SETTLE  = CW'(WR_SETTLE);

   state_t        state, next_state;
   logic [CW-1:0] cnt;
   logic [24:0]   addr_q;
   logic          we_q;
   logic [7:0]    wdata_q;
   logic [15:0]   word_q;
   logic          err_q;
   logic          ack_q;
   logic          buf_valid;
   logic [23:0]   buf_tag;
   logic [15:0]   buf_word;

   logic          hit, rd_take, issue_rd, issue_wr, to_err;
   logic [15:0]   merged;
   logic [7:0]    lane;

   // A ready beat arriving while its ack is still outstanding is the same beat.
   assign rd_take = ram_rd_ready && !ack_q;
   assign hit     = BUF_EN && buf_valid && (buf_tag == addr_q[24:1]);
   assign merged  = addr_q[0] ? {wdata_q, word_q[7:0]} : {word_q[15:8], wdata_q};
   assign lane    = addr_q[0] ? word_q[15:8] : word_q[7:0];

   always_comb begin
      next_state = state;
      issue_rd   = 1'b0;
      issue_wr   = 1'b0;
      to_err     = 1'b0;
      case (state)
         S_IDLE:     if (cpu_req) next_state = S_ACCEPT;
         // Tag compare runs on the registered address, one cycle after acceptance.
         S_ACCEPT:   next_state = (!we_q && hit) ? S_DONE : S_RD_ISSUE;
         S_RD_ISSUE: if (!ram_busy) begin
            issue_rd   = 1'b1;
            next_state = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            if (rd_take) begin
               next_state = we_q ? S_MERGE : S_DONE;
            end else if (cnt >= TO_LAST) begin
               next_state = S_DONE;
               to_err     = 1'b1;
            end
         end
         S_MERGE:    next_state = S_WR_ISSUE;
         S_WR_ISSUE: if (!ram_busy) begin
            issue_wr   = 1'b1;
            next_state = S_WR_WAIT;
         end
         S_WR_WAIT: begin
            if ((cnt >= SETTLE) && !ram_busy) begin
               next_state = S_DONE;
            end else if (cnt >= TO_LAST) begin
               next_state = S_DONE;
               to_err     = 1'b1;
            end
         end
         S_DONE:     next_state = S_IDLE;
         default:    next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         addr_q    <= '0;
         we_q      <= 1'b0;
         wdata_q   <= '0;
         word_q    <= '0;
         err_q     <= 1'b0;
         ack_q     <= 1'b0;
         buf_valid <= 1'b0;
         buf_tag   <= '0;
         buf_word  <= '0;
      end else begin
         state <= next_state;
         ack_q <= rd_take;
         if (next_state != state) cnt <= '0;
         else if (cnt != CNT_MAX) cnt <= cnt + CW'(1);

         if (state == S_IDLE && cpu_req) begin
            addr_q  <= cpu_addr;
            we_q    <= cpu_we;
            wdata_q <= cpu_wdata;
            err_q   <= 1'b0;
         end
         if (state == S_ACCEPT && !we_q && hit) word_q <= buf_word;
         if (state == S_RD_WAIT && rd_take) begin
            word_q <= ram_rd_data;
            if (!we_q && BUF_EN) begin
               buf_valid <= 1'b1;
               buf_tag   <= addr_q[24:1];
               buf_word  <= ram_rd_data;
            end
         end
         if (to_err) err_q <= 1'b1;
         if (state == S_MERGE) word_q <= merged;
         // Write-through keeps the buffer coherent with the word just stored.
         if (issue_wr && buf_valid && (buf_tag == addr_q[24:1])) buf_word <= word_q;
      end
   end

   assign ram_rd_en   = issue_rd && !rst;
   assign ram_wr_en   = issue_wr && !rst;
   assign ram_rd_ack  = ack_q && !rst;
   assign ram_addr    = addr_q[24:1];
   assign ram_wr_data = word_q;
   assign cpu_done    = (state == S_DONE) && !rst;
   assign cpu_err     = cpu_done && err_q;
   assign cpu_rdata   = (cpu_done && !we_q && !err_q) ? lane : 8'h00;
   assign cpu_stall   = (state != S_IDLE);
   assign dbg_state   = state;

endmodule
